// File: rtl/vga_monitor.sv
// vga_monitor: VGA sync timing checker, lock FSM and active-pixel extractor.
// Define VGA_MONITOR_SIG_EN to add a per-frame CRC-16 signature on frame_sig.
module vga_monitor #(
  parameter int H_SYNC_CYC     = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int H_ACTIVE_VIDEO = 640,
  parameter int H_LINE         = 800,
  parameter int V_SYNC_CYC     = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int V_ACTIVE_VIDEO = 480,
  parameter int V_LINE         = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  vgaR,
  input  logic [2:0]  vgaG,
  input  logic [2:0]  vgaB,
  input  logic        vgaHs,
  input  logic        vgaVs,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [8:0]  pixel_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] CMAX  = 10'd1023;
  localparam logic [9:0] H_END = 10'(H_LINE - 1);
  localparam logic [9:0] V_END = 10'(V_LINE - 1);
  localparam logic [9:0] H_LO  = 10'(H_SYNC_CYC + H_BACK_PORCH);
  localparam logic [9:0] H_HI  =
    10'(H_SYNC_CYC + H_BACK_PORCH + H_ACTIVE_VIDEO);
  localparam logic [9:0] V_LO  = 10'(V_SYNC_CYC + V_BACK_PORCH);
  localparam logic [9:0] V_HI  =
    10'(V_SYNC_CYC + V_BACK_PORCH + V_ACTIVE_VIDEO);
  localparam logic [9:0] X_END = 10'(H_ACTIVE_VIDEO - 1);
  localparam logic [9:0] Y_END = 10'(V_ACTIVE_VIDEO - 1);

  typedef enum logic [1:0] {SEARCH, TRAIN, LOCK} state_t;
  state_t state;

  logic       hs1, hs1_d, vs1, vs_last;
  logic [8:0] rgb1;
  logic [9:0] hcnt_q, vcnt_q, hcnt, vcnt;
  logic [9:0] x, y;
  logic [7:0] err_inc;
  logic       fall, vstart, line_err, frame_err, err;
  logic       in_act, last_px;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1     <= 1'b0;
      hs1_d   <= 1'b0;
      vs1     <= 1'b0;
      vs_last <= 1'b0;
      rgb1    <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      hs1    <= vgaHs;
      hs1_d  <= hs1;
      vs1    <= vgaVs;
      rgb1   <= {vgaR, vgaG, vgaB};
      hcnt_q <= hcnt;
      vcnt_q <= vcnt;
      if (fall) vs_last <= vs1;
    end
  end

  // hcnt/vcnt are the coordinates of the sample now in stage 1
  always_comb begin
    fall   = hs1_d & ~hs1;
    vstart = fall & ~vs1 & vs_last;
    if (fall) hcnt = '0;
    else if (hcnt_q == CMAX) hcnt = CMAX;
    else hcnt = hcnt_q + 10'd1;
    vcnt = vcnt_q;
    if (vstart) vcnt = '0;
    else if (fall && vcnt_q != CMAX) vcnt = vcnt_q + 10'd1;
    line_err  = (fall && hcnt_q != H_END) ||
                (hcnt == CMAX && hcnt_q != CMAX);
    frame_err = vstart && vcnt_q != V_END;
    err       = line_err | frame_err;
    err_inc   = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
    x         = hcnt - H_LO;
    y         = vcnt - V_LO;
    in_act    = (state == LOCK) &&
                hcnt >= H_LO && hcnt < H_HI &&
                vcnt >= V_LO && vcnt < V_HI;
    last_px   = in_act && x == X_END && y == Y_END;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      locked  <= 1'b0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        SEARCH: if (vstart) state <= TRAIN;
        TRAIN: begin
          if (err) begin
            state   <= SEARCH;
            err_cnt <= err_inc;
          end else if (vstart) begin
            state  <= LOCK;
            locked <= 1'b1;
          end
        end
        LOCK: begin
          if (err) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            err_cnt <= err_inc;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= in_act;
      pixel_x     <= in_act ? x : '0;
      pixel_y     <= in_act ? y : '0;
      pixel_rgb   <= in_act ? rgb1 : '0;
      frame_done  <= last_px;
    end
  end

`ifdef VGA_MONITOR_SIG_EN
  logic [15:0] crc, crc_nxt, sig;

  // CRC-16-CCITT, pixel bits shifted in MSB first
  always_comb begin
    crc_nxt = crc;
    for (int i = 8; i >= 0; i--) begin
      crc_nxt = {crc_nxt[14:0], 1'b0} ^
        ({16{crc_nxt[15] ^ rgb1[i]}} & 16'h1021);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 16'hFFFF;
      sig <= '0;
    end else if (vstart) begin
      crc <= 16'hFFFF;
    end else if (in_act) begin
      crc <= crc_nxt;
      if (last_px) sig <= crc_nxt;
    end
  end

  assign frame_sig = sig;
`else
  assign frame_sig = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_monitor.sv
// tb_vga_monitor: randomized VGA streams against a per-sample reference model.
// Small timing parameters keep each frame short.
`timescale 1ns/1ps
module tb_vga_monitor;

  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int HA  = 16;
  localparam int HL  = 28;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VA  = 8;
  localparam int VL  = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  r, g, b;
  logic        hs, vs;
  logic        locked, pixel_valid, frame_done;
  logic [9:0]  pixel_x, pixel_y;
  logic [8:0]  pixel_rgb;
  logic [15:0] frame_sig;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  vga_monitor #(
    .H_SYNC_CYC(HS), .H_BACK_PORCH(HBP),
    .H_ACTIVE_VIDEO(HA), .H_LINE(HL),
    .V_SYNC_CYC(VS), .V_BACK_PORCH(VBP),
    .V_ACTIVE_VIDEO(VA), .V_LINE(VL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vgaR(r), .vgaG(g), .vgaB(b),
    .vgaHs(hs), .vgaVs(vs),
    .locked(locked), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .frame_done(frame_done),
    .frame_sig(frame_sig), .err_cnt(err_cnt)
  );

  typedef struct {
    bit lk;
    bit pv;
    int x;
    int y;
    int rgb;
    bit fd;
    int sig;
    int err;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_pv = 0;
  int cnt_fd = 0;

  exp_t e_prev, e_nxt;
  int   m_h, m_v, m_st, m_err, m_sig;
  bit   m_phs, m_vlast;
  bit [8:0] m_pix[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_of(input bit [8:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[k]) begin
      for (int i = 8; i >= 0; i--) begin
        c = c ^ {q[k][i], 15'b0};
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic int sig_of(input bit [8:0] q[$]);
`ifdef VGA_MONITOR_SIG_EN
    return int'(crc_of(q));
`else
    return 0;
`endif
  endfunction

  function automatic int ramp_sig();
    bit [8:0] q[$];
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        q.push_back(9'(xx));
    return sig_of(q);
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_st = 0;
    m_err = 0; m_sig = 0;
    m_phs = 0; m_vlast = 0;
    m_pix.delete();
    e_prev = '{default: 0};
  endtask

  task automatic model_step(input bit h, input bit v,
                            input bit [8:0] c);
    bit fall, vst, err, pv;
    int hp, vp, x, y;
    fall = m_phs && !h;
    hp = m_h;
    vp = m_v;
    m_h = fall ? 0 : (m_h < 1023 ? m_h + 1 : 1023);
    vst = fall && !v && m_vlast;
    if (fall) begin
      m_v = vst ? 0 : (m_v < 1023 ? m_v + 1 : 1023);
      m_vlast = v;
    end
    err = (fall && hp != HL - 1) ||
          (m_h == 1023 && hp != 1023) ||
          (vst && vp != VL - 1);
    x = m_h - (HS + HBP);
    y = m_v - (VS + VBP);
    pv = (m_st == 2) && x >= 0 && x < HA && y >= 0 && y < VA;
    e_nxt.pv  = pv;
    e_nxt.x   = pv ? x : 0;
    e_nxt.y   = pv ? y : 0;
    e_nxt.rgb = pv ? int'(c) : 0;
    e_nxt.fd  = pv && x == HA - 1 && y == VA - 1;
    if (vst) m_pix.delete();
    if (pv) m_pix.push_back(c);
    if (e_nxt.fd) m_sig = sig_of(m_pix);
    e_nxt.sig = m_sig;
    case (m_st)
      0: if (vst) m_st = 1;
      1: begin
        if (err) begin
          m_st = 0;
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (vst) m_st = 2;
      end
      default: begin
        if (err) begin
          m_st = 0;
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
      end
    endcase
    e_nxt.lk  = (m_st == 2);
    e_nxt.err = m_err;
    m_phs = h;
  endtask

  task automatic compare_out(input exp_t e);
    check("locked", 32'(locked), 32'(e.lk));
    check("pixel_valid", 32'(pixel_valid), 32'(e.pv));
    check("pixel_x", 32'(pixel_x), e.x);
    check("pixel_y", 32'(pixel_y), e.y);
    check("pixel_rgb", 32'(pixel_rgb), e.rgb);
    check("frame_done", 32'(frame_done), 32'(e.fd));
    check("frame_sig", 32'(frame_sig), e.sig);
    check("err_cnt", 32'(err_cnt), e.err);
  endtask

  task automatic cycle(input bit h, input bit v, input bit [8:0] c);
    @(negedge clk);
    hs = h;
    vs = v;
    {r, g, b} = c;
    model_step(h, v, c);
    @(posedge clk);
    #1;
    compare_out(e_prev);
    cnt_pv += int'(pixel_valid);
    cnt_fd += int'(frame_done);
    e_prev = e_nxt;
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    z = '{default: 0};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare_out(z);
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic gen_frame(input bit ramp, input int short_line,
                           input int hold_at, input int rst_at);
    int k, len;
    bit act;
    bit [8:0] c;
    k = 0;
    for (int l = 0; l < VL; l++) begin
      len = (l == short_line) ? HL - 1 : HL;
      for (int p = 0; p < len; p++) begin
        act = p >= HS + HBP && p < HS + HBP + HA &&
              l >= VS + VBP && l < VS + VBP + VA;
        c = (ramp && act) ? 9'(p - HS - HBP) : 9'($urandom);
        if (k == rst_at) do_reset(3);
        if (k == hold_at)
          repeat (1100) cycle(1'b1, l >= VS, 9'($urandom));
        cycle(p >= HS, l >= VS, c);
        k++;
      end
    end
  endtask

  initial begin
    int rs;
    hs = 1'b1;
    vs = 1'b1;
    {r, g, b} = 9'h0;
    do_reset(4);

    repeat (2) gen_frame(1'b0, -1, -1, -1);
    cnt_pv = 0;
    cnt_fd = 0;
    gen_frame(1'b0, -1, -1, -1);
    check("lock_frame3", 32'(locked), 1);
    check("pv_per_frame", cnt_pv, HA * VA);
    check("fd_per_frame", cnt_fd, 1);
    check("err_clean", 32'(err_cnt), 0);

    gen_frame(1'b1, -1, -1, -1);
    check("sig_ramp_a", 32'(frame_sig), ramp_sig());
    gen_frame(1'b1, -1, -1, -1);
    check("sig_ramp_b", 32'(frame_sig), ramp_sig());

    gen_frame(1'b0, 5, -1, -1);
    check("short_unlock", 32'(locked), 0);
    check("short_err", 32'(err_cnt), 1);
    repeat (2) gen_frame(1'b0, -1, -1, -1);
    check("short_relock", 32'(locked), 1);

    gen_frame(1'b0, -1, HL * 6 + 10, -1);
    check("hold_unlock", 32'(locked), 0);
    check("hold_err", 32'(err_cnt), 2);
    repeat (2) gen_frame(1'b0, -1, -1, -1);
    check("hold_relock", 32'(locked), 1);

    rs = $urandom_range(HL * (VS + 1), HL * (VL - 2));
    cnt_fd = 0;
    gen_frame(1'b0, -1, -1, rs);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_no_fd", cnt_fd, 0);
    gen_frame(1'b0, -1, -1, -1);
    cnt_pv = 0;
    cnt_fd = 0;
    gen_frame(1'b0, -1, -1, -1);
    check("rst_relock", 32'(locked), 1);
    check("rst_pv_cnt", cnt_pv, HA * VA);
    check("rst_fd_cnt", cnt_fd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
